// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared widths and round-robin helper functions for the data-memory arbiter
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_CORES  = 8;
    localparam int IDX_W      = 3;

    // One-hot winner: first set bit of req searching from ptr upward, wrapping at n.
    function automatic logic [MAX_CORES-1:0] rr_pick(
        input logic [MAX_CORES-1:0] req,
        input logic [IDX_W-1:0]     ptr,
        input int                   n
    );
        logic [MAX_CORES-1:0] g;
        logic                 found;
        int                   c;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CORES; k++) begin
            if (k < n) begin
                c = (int'(ptr) + k) % n;
                if (!found && req[c]) begin
                    found = 1'b1;
                    g[c]  = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin find-first, reusable for any shared port
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_c;

    // Rotate by ptr, find first set bit, and map back to the original core index in one pass.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            w_c = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_c]) begin
                o_valid    = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = IW'(w_c);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of one data memory among cores; DMEM_LOCK_EN adds bus lock
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    input  logic [NUM_CORES-1:0]        lock,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IW-1:0]        r_ptr;
    logic                 r_rd_pend;
    logic [IW-1:0]        r_rd_id;
    logic [NUM_CORES-1:0] w_req_elig;
    logic [NUM_CORES-1:0] w_gnt;
    logic [IW-1:0]        w_idx;
    logic                 w_valid;
    logic                 w_ptr_hold;

`ifdef DMEM_LOCK_EN
    logic          r_owner_valid;
    logic [IW-1:0] r_owner_id;

    always_comb begin
        w_req_elig = req;
        if (r_owner_valid) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                w_req_elig[i] = req[i] && (r_owner_id == IW'(i));
            end
        end
    end

    // Owner keeps the bus until it presents lock=0; that last cycle may still carry an access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_valid <= 1'b0;
            r_owner_id    <= '0;
        end else if (r_owner_valid) begin
            if (!lock[r_owner_id]) begin
                r_owner_valid <= 1'b0;
            end
        end else if (w_valid && lock[w_idx]) begin
            r_owner_valid <= 1'b1;
            r_owner_id    <= w_idx;
        end
    end

    assign w_ptr_hold = r_owner_valid;
`else
    logic w_unused_lock;

    assign w_unused_lock = |lock;
    assign w_req_elig    = req;
    assign w_ptr_hold    = 1'b0;
`endif

    rr_priority_picker #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_picker (
        .i_req   (w_req_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign gnt = w_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_gnt[i]) begin
                mem_we    = we[i];
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_valid && !w_ptr_hold) begin
            r_ptr <= (w_idx == IW'(NUM_CORES - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Remember who issued a read so the returning word can be tagged one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_rd_pend <= w_valid && !mem_we;
            r_rd_id   <= w_idx;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rvalid[i] = r_rd_pend && (r_rd_id == IW'(i));
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req, we, lock, gnt, rvalid;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;

    always #5 clock = ~clock;

    dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock      (lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            8'h00:   return 16'h0011;
            8'h01:   return 16'h0022;
            8'h15:   return 16'h1234;
            default: return (16'(a) * 16'h0101) ^ 16'h5a5a;
        endcase
    endfunction

    // Memory attached to the DUT: synchronous read, one cycle latency.
    logic [DW-1:0] tb_mem [256];
    bit            mem_ready;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(8'(i));
            mem_rdata <= '0;
            mem_ready <= 1'b1;
        end else begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Core-side request state and the reference model.
    bit            c_req [N];
    bit            c_we  [N];
    bit            c_lock[N];
    logic [AW-1:0] c_addr[N];
    logic [DW-1:0] c_wd  [N];

    logic [DW-1:0] sh_mem [256];
    int            m_ptr, m_pend_core, m_owner, m_win, granted;
    bit            m_pend, m_own;
    logic [DW-1:0] m_pend_data;

    logic [N-1:0]  s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_mem_we;
    logic [AW-1:0] s_mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]            = c_req[i];
            we[i]             = c_we[i];
            lock[i]           = c_lock[i];
            addr[i*AW +: AW]  = c_addr[i];
            wdata[i*DW +: DW] = c_wd[i];
        end
    endtask

    function automatic int pick();
        int w = -1;
        for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (w < 0 && c_req[c] && (!m_own || c == m_owner)) w = c;
        end
        return w;
    endfunction

    task automatic cycle();
        logic [N-1:0] eg, erv;
        drive();
        @(negedge clock);
        m_win = pick();
        eg  = '0;
        erv = '0;
        if (m_win >= 0) eg[m_win] = 1'b1;
        if (m_pend) erv[m_pend_core] = 1'b1;
        s_gnt      = gnt;
        s_rvalid   = rvalid;
        s_rdata    = rdata;
        s_mem_we   = mem_we;
        s_mem_addr = mem_addr;
        check("gnt", 32'(gnt), 32'(eg));
        check("mem_we", 32'(mem_we), (m_win >= 0) ? 32'(c_we[m_win]) : 32'd0);
        check("mem_addr", 32'(mem_addr), (m_win >= 0) ? 32'(c_addr[m_win]) : 32'd0);
        check("mem_wdata", 32'(mem_wdata), (m_win >= 0) ? 32'(c_wd[m_win]) : 32'd0);
        check("rvalid", 32'(rvalid), 32'(erv));
        if (m_pend) check("rdata", 32'(rdata), 32'(m_pend_data));
        @(posedge clock);
        m_pend = 1'b0;
        if (m_win >= 0) begin
            if (c_we[m_win]) sh_mem[c_addr[m_win]] = c_wd[m_win];
            else begin
                m_pend      = 1'b1;
                m_pend_core = m_win;
                m_pend_data = sh_mem[c_addr[m_win]];
            end
        end
`ifdef DMEM_LOCK_EN
        if (m_own) begin
            if (!c_lock[m_owner]) m_own = 1'b0;
        end else if (m_win >= 0) begin
            m_ptr = (m_win + 1) % N;
            if (c_lock[m_win]) begin
                m_own   = 1'b1;
                m_owner = m_win;
            end
        end
`else
        if (m_win >= 0) m_ptr = (m_win + 1) % N;
`endif
        granted = m_win;
        #1;
    endtask

    task automatic set_core(input int i, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_req[i]  = r;
        c_we[i]   = w;
        c_addr[i] = a;
        c_wd[i]   = d;
    endtask

    task automatic rand_update();
        for (int i = 0; i < N; i++) begin
            if (i == granted || !c_req[i]) begin
                c_req[i]  = ($urandom_range(0, 2) != 0);
                c_we[i]   = 1'($urandom_range(0, 1));
                c_addr[i] = 8'($urandom_range(0, 15));
                c_wd[i]   = 16'($urandom);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sh_mem[i] = init_val(8'(i));
        for (int i = 0; i < N; i++) begin
            set_core(i, 1'b0, 1'b0, '0, '0);
            c_lock[i] = 1'b0;
        end
        m_ptr = 0; m_pend = 0; m_own = 0; m_owner = 0; m_pend_core = 0; m_pend_data = '0;
        granted = -1;
        reset_n = 1'b0;
        drive();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // single read by core 2
        set_core(2, 1'b1, 1'b0, 8'h15, 16'h0);
        cycle();
        check("t1_gnt", 32'(s_gnt), 32'h4);
        check("t1_addr", 32'(s_mem_addr), 32'h15);
        c_req[2] = 1'b0;
        cycle();
        check("t1_rvalid", 32'(s_rvalid), 32'h4);
        check("t1_rdata", 32'(s_rdata), 32'h1234);

        // write then read back by core 1
        set_core(1, 1'b1, 1'b1, 8'h40, 16'hBEEF);
        cycle();
        check("t2_we", 32'(s_mem_we), 32'd1);
        c_we[1] = 1'b0;
        cycle();
        check("t2_no_rvalid", 32'(s_rvalid), 32'd0);
        c_req[1] = 1'b0;
        cycle();
        check("t2_rvalid", 32'(s_rvalid), 32'h2);
        check("t2_rdata", 32'(s_rdata), 32'hBEEF);

        // back-to-back reads from cores 0 and 3
        set_core(0, 1'b1, 1'b0, 8'h00, 16'h0);
        cycle();
        c_req[0] = 1'b0;
        set_core(3, 1'b1, 1'b0, 8'h01, 16'h0);
        cycle();
        check("t4_rvalid0", 32'(s_rvalid), 32'h1);
        check("t4_rdata0", 32'(s_rdata), 32'h0011);
        c_req[3] = 1'b0;
        cycle();
        check("t4_rvalid3", 32'(s_rvalid), 32'h8);
        check("t4_rdata3", 32'(s_rdata), 32'h0022);

        // round robin with every core requesting continuously
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 8'(i + 2), 16'h0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("t3_order", 32'(s_gnt), 32'(1 << (k % N)));
        end
        for (int i = 0; i < N; i++) c_req[i] = 1'b0;
        cycle();

        // reset in the cycle after a read grant
        set_core(0, 1'b1, 1'b0, 8'h05, 16'h0);
        cycle();
        c_req[0] = 1'b0;
        drive();
        reset_n = 1'b0;
        m_pend = 1'b0; m_ptr = 0; m_own = 1'b0;
        @(negedge clock);
        check("t5_rvalid", 32'(rvalid), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 8'(i), 16'h0);
        cycle();
        check("t5_first", 32'(s_gnt), 32'h1);
        for (int i = 0; i < N; i++) c_req[i] = 1'b0;
        cycle();

`ifdef DMEM_LOCK_EN
        // core 1 locks the bus for three accesses while cores 0 and 2 wait
        while (m_ptr != 1) begin
            set_core(m_ptr, 1'b1, 1'b0, 8'h03, 16'h0);
            cycle();
            for (int i = 0; i < N; i++) c_req[i] = 1'b0;
        end
        set_core(0, 1'b1, 1'b0, 8'h07, 16'h0);
        set_core(2, 1'b1, 1'b0, 8'h08, 16'h0);
        set_core(1, 1'b1, 1'b1, 8'h09, 16'h0101);
        c_lock[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) c_lock[1] = 1'b0;
            cycle();
            check("t6_lock", 32'(s_gnt), 32'h2);
            c_wd[1] = c_wd[1] + 16'h1;
        end
        c_req[1] = 1'b0;
        cycle();
        check("t6_after", 32'(s_gnt), 32'h4);
        for (int i = 0; i < N; i++) c_req[i] = 1'b0;
        cycle();
`endif

        granted = -1;
        for (int k = 0; k < 400; k++) begin
            rand_update();
            cycle();
        end
        for (int i = 0; i < N; i++) c_req[i] = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
